// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants; the datapath width is also used by decode.
package if_pkg;

    localparam int IF_W = 8;
    localparam logic [IF_W-1:0] NOP_INST_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [IF_W-1:0] inst;
        logic [IF_W-1:0] pc;
    } if_entry_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction-memory request/ack port, decode handshake and IF/ID register.
interface if_stage_if;
    import if_pkg::*;

    logic            imem_req;
    logic [IF_W-1:0] imem_addr;
    logic            imem_ack;
    logic [IF_W-1:0] imem_data;
    logic            stall;
    logic            redirect;
    logic [IF_W-1:0] redirect_target;
    logic [IF_W-1:0] inst;
    logic [IF_W-1:0] PCout;
    logic            inst_valid;

    modport master (
        output imem_req, imem_addr, inst, PCout, inst_valid,
        input  imem_ack, imem_data, stall, redirect, redirect_target
    );

    modport slave (
        input  imem_req, imem_addr, inst, PCout, inst_valid,
        output imem_ack, imem_data, stall, redirect, redirect_target
    );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry {inst, pc} holding buffer for a fetch that returns while decode is stalled.
module if_skid_buf
    import if_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      load,
    input  logic      unload,
    input  logic      flush,
    input  if_entry_t din,
    output if_entry_t dout,
    output logic      full
);

    if_entry_t data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            full   <= 1'b0;
            data_q <= '0;
        end else begin
            if (flush) begin
                full <= 1'b0;
            end else if (load) begin
                full <= 1'b1;
            end else if (unload) begin
                full <= 1'b0;
            end
            if (load) begin
                data_q <= din;
            end
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, request/ack memory port and IF/ID register.
// Optional stall/flush statistics counters are built when IF_STALL_CNT_EN is defined.
//
//   state   | meaning
//   S_FETCH | request at PC; load IF/ID or skid on ack
//   S_HOLD  | skid full, no request; wait for decode to free IF/ID
//   S_DRAIN | redirected with request outstanding; wait for ack, drop data
module if_stage
    import if_pkg::*;
#(
    parameter logic [IF_W-1:0] RESET_PC = 8'h00,
    parameter logic [IF_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    if_stage_if.master    bus
`ifdef IF_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt,
    output logic [7:0]    flush_cnt
`endif
);

    if_state_t       state_q, state_d;
    logic [IF_W-1:0] pc_q, pc_d;
    logic [IF_W-1:0] tgt_q, tgt_d;
    logic [IF_W-1:0] inst_q, inst_d;
    logic [IF_W-1:0] pcout_q, pcout_d;
    logic            valid_q, valid_d;

    logic            skid_load, skid_unload, skid_flush, skid_full;
    if_entry_t       skid_din, skid_dout;

    logic            ack_v;
    logic            out_free;

    assign bus.imem_req   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign bus.imem_addr  = pc_q;
    assign bus.inst       = inst_q;
    assign bus.PCout      = pcout_q;
    assign bus.inst_valid = valid_q;

    assign ack_v    = bus.imem_ack && bus.imem_req;
    assign out_free = !valid_q || !bus.stall;
    assign skid_din = '{inst: bus.imem_data, pc: pc_q};

    if_skid_buf u_skid (
        .clock  (clock),
        .reset  (reset),
        .load   (skid_load),
        .unload (skid_unload),
        .flush  (skid_flush),
        .din    (skid_din),
        .dout   (skid_dout),
        .full   (skid_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            inst_q  <= NOP_INST;
            pcout_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            inst_q  <= inst_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        inst_d      = inst_q;
        pcout_d     = pcout_q;
        valid_d     = valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;

        if (bus.redirect) begin
            valid_d    = 1'b0;
            inst_d     = NOP_INST;
            skid_flush = 1'b1;
            case (state_q)
                S_FETCH: begin
                    // Without an ack the address must stay put until memory answers.
                    if (ack_v) begin
                        pc_d = bus.redirect_target;
                    end else begin
                        tgt_d   = bus.redirect_target;
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (ack_v) begin
                        pc_d    = bus.redirect_target;
                        state_d = S_FETCH;
                    end else begin
                        tgt_d = bus.redirect_target;
                    end
                end
                default: begin
                    pc_d    = bus.redirect_target;
                    state_d = S_FETCH;
                end
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ack_v) begin
                        pc_d = pc_q + 8'd1;
                        if (out_free) begin
                            inst_d  = bus.imem_data;
                            pcout_d = pc_q;
                            valid_d = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = S_HOLD;
                        end
                    end else if (out_free) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                S_HOLD: begin
                    if (out_free) begin
                        inst_d      = skid_dout.inst;
                        pcout_d     = skid_dout.pc;
                        valid_d     = 1'b1;
                        skid_unload = 1'b1;
                        state_d     = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (out_free) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                    if (ack_v) begin
                        pc_d    = tgt_q;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

`ifdef IF_STALL_CNT_EN
    // A redirect discards work if IF/ID, the skid or an outstanding request holds something.
    logic discard;
    assign discard = valid_q || skid_full || bus.imem_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (valid_q && bus.stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (bus.redirect && discard && (flush_cnt != 8'hFF)) begin
                flush_cnt <= flush_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model returns addr ^ 8'hA5 after a programmable ack latency.
module tb_if_stage;
    import if_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;
    int   lat;
    int   lat_cnt;
    logic force_ack;
    logic sb_on;
    logic [15:0] sb[$];

    if_stage_if bus ();

`ifdef IF_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [7:0]  flush_cnt;
`endif

    if_stage dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign bus.imem_ack  = (bus.imem_req && (lat_cnt >= lat)) || force_ack;
    assign bus.imem_data = bus.imem_addr ^ 8'hA5;

    always_ff @(posedge clock) begin
        if (reset || !bus.imem_req || bus.imem_ack) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] pc);
        sb.push_back({pc ^ 8'hA5, pc});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Decode takes IF/ID when valid, not stalled and not being flushed.
    always @(negedge clock) begin
        if (sb_on && !reset && bus.inst_valid && !bus.stall && !bus.redirect) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pc", {8'h00, bus.PCout}, 16'h0100);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                chk("sb_pc", {8'h00, bus.PCout}, {8'h00, e[7:0]});
                chk("sb_inst", {8'h00, bus.inst}, {8'h00, e[15:8]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; lat = 0; force_ack = 1'b0; sb_on = 1'b0;
        bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_target = 8'h00;
        step(); step();
        chk("rst_valid", {15'd0, bus.inst_valid}, 16'd0);
        chk("rst_inst", {8'h00, bus.inst}, 16'h0000);
        chk("rst_pcout", {8'h00, bus.PCout}, 16'h0000);
        chk("rst_addr", {8'h00, bus.imem_addr}, 16'h0000);
        chk("rst_req", {15'd0, bus.imem_req}, 16'd1);

        // Sequential fetch, zero-wait memory
        sb_on = 1'b1;
        for (int i = 0; i < 5; i++) push(8'(i));
        reset = 1'b0;
        step();
        chk("first_valid", {15'd0, bus.inst_valid}, 16'd1);
        chk("first_pc", {8'h00, bus.PCout}, 16'h0000);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("seq_valid", {15'd0, bus.inst_valid}, 16'd1);
            chk("seq_pc", {8'h00, bus.PCout}, 16'(i));
        end

        // Back-pressure into skid
        bus.stall = 1'b1;
        step();
        chk("hold_req", {15'd0, bus.imem_req}, 16'd0);
        chk("hold_pcout", {8'h00, bus.PCout}, 16'h0004);
        chk("hold_skid_full", {15'd0, dut.skid_full}, 16'd1);
        chk("hold_skid_pc", {8'h00, dut.skid_dout.pc}, 16'h0005);
        chk("hold_addr", {8'h00, bus.imem_addr}, 16'h0006);
        step(); step();
        chk("hold3_pcout", {8'h00, bus.PCout}, 16'h0004);
        chk("hold3_req", {15'd0, bus.imem_req}, 16'd0);
        push(8'h05); push(8'h06);
        bus.stall = 1'b0;
        step(); chk("unstall_pc5", {8'h00, bus.PCout}, 16'h0005);
        step(); chk("unstall_pc6", {8'h00, bus.PCout}, 16'h0006);
        step(); chk("unstall_pc7", {8'h00, bus.PCout}, 16'h0007);

        // Redirect with a pending request
        bus.redirect = 1'b1; bus.redirect_target = 8'h10;
        step();
        chk("redir10_valid", {15'd0, bus.inst_valid}, 16'd0);
        chk("redir10_inst", {8'h00, bus.inst}, 16'h0000);
        chk("redir10_addr", {8'h00, bus.imem_addr}, 16'h0010);
        bus.redirect = 1'b0; lat = 2;
        step();
        bus.redirect = 1'b1; bus.redirect_target = 8'h40;
        step();
        bus.redirect = 1'b0;
        chk("drain_addr", {8'h00, bus.imem_addr}, 16'h0010);
        chk("drain_req", {15'd0, bus.imem_req}, 16'd1);
        chk("drain_state", {14'd0, dut.state_q}, {14'd0, S_DRAIN});
        step();
        chk("drain_done_addr", {8'h00, bus.imem_addr}, 16'h0040);
        chk("drain_done_valid", {15'd0, bus.inst_valid}, 16'd0);
        push(8'h40);
        for (int i = 0; i < 8 && !bus.inst_valid; i++) step();
        chk("redir40_valid", {15'd0, bus.inst_valid}, 16'd1);
        chk("redir40_pc", {8'h00, bus.PCout}, 16'h0040);
        lat = 0;
        step();
        chk("post40_pc", {8'h00, bus.PCout}, 16'h0041);

        // Redirect while stalled with skid full and a stray ack
        bus.redirect = 1'b1; bus.redirect_target = 8'h20;
        step();
        bus.redirect = 1'b0;
        chk("redir20_addr", {8'h00, bus.imem_addr}, 16'h0020);
        step();
        chk("redir20_pc", {8'h00, bus.PCout}, 16'h0020);
        bus.stall = 1'b1;
        step();
        chk("full_skid_pc", {8'h00, dut.skid_dout.pc}, 16'h0021);
        chk("full_addr", {8'h00, bus.imem_addr}, 16'h0022);
        chk("full_req", {15'd0, bus.imem_req}, 16'd0);
        bus.redirect = 1'b1; bus.redirect_target = 8'h80; force_ack = 1'b1;
        step();
        bus.redirect = 1'b0; force_ack = 1'b0; bus.stall = 1'b0;
        chk("redir80_valid", {15'd0, bus.inst_valid}, 16'd0);
        chk("redir80_skid", {15'd0, dut.skid_full}, 16'd0);
        chk("redir80_addr", {8'h00, bus.imem_addr}, 16'h0080);
        chk("redir80_state", {14'd0, dut.state_q}, {14'd0, S_FETCH});
        push(8'h80); push(8'h81);
        step(); chk("pc80", {8'h00, bus.PCout}, 16'h0080);
        step(); chk("pc81", {8'h00, bus.PCout}, 16'h0081);
        step(); chk("pc82", {8'h00, bus.PCout}, 16'h0082);

        // Wrap and reset during S_HOLD
        bus.redirect = 1'b1; bus.redirect_target = 8'hFE;
        step();
        bus.redirect = 1'b0;
        chk("redirFE_addr", {8'h00, bus.imem_addr}, 16'h00FE);
        push(8'hFE); push(8'hFF);
        step(); chk("wrap_fe", {8'h00, bus.PCout}, 16'h00FE);
        step(); chk("wrap_ff", {8'h00, bus.PCout}, 16'h00FF);
        step();
        chk("wrap_00", {8'h00, bus.PCout}, 16'h0000);
        chk("wrap_00_inst", {8'h00, bus.inst}, 16'h00A5);
        chk("wrap_addr", {8'h00, bus.imem_addr}, 16'h0001);
        bus.stall = 1'b1;
        step();
        chk("wrap_hold_req", {15'd0, bus.imem_req}, 16'd0);
        reset = 1'b1;
        step();
        chk("midrst_valid", {15'd0, bus.inst_valid}, 16'd0);
        chk("midrst_addr", {8'h00, bus.imem_addr}, 16'h0000);
        chk("midrst_state", {14'd0, dut.state_q}, {14'd0, S_FETCH});
        chk("midrst_skid", {15'd0, dut.skid_full}, 16'd0);
        chk("midrst_inst", {8'h00, bus.inst}, 16'h0000);
        reset = 1'b0; bus.stall = 1'b0;
        push(8'h00); push(8'h01); push(8'h02);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("restart_pc", {8'h00, bus.PCout}, 16'(i));
        end
        step();
        sb_on = 1'b0;
        chk("sb_empty", 16'(sb.size()), 16'd0);

`ifdef IF_STALL_CNT_EN
        reset = 1'b1;
        step();
        chk("cnt_rst_stall", stall_cnt, 16'd0);
        chk("cnt_rst_flush", {8'h00, flush_cnt}, 16'd0);
        reset = 1'b0;
        step();
        bus.stall = 1'b1;
        repeat (5) step();
        bus.stall = 1'b0;
        bus.redirect = 1'b1; bus.redirect_target = 8'h30;
        step();
        bus.redirect_target = 8'h31;
        step();
        bus.redirect = 1'b0;
        chk("cnt_stall", stall_cnt, 16'd5);
        chk("cnt_flush", {8'h00, flush_cnt}, 16'd2);
        reset = 1'b1;
        step();
        chk("cnt_clr_stall", stall_cnt, 16'd0);
        chk("cnt_clr_flush", {8'h00, flush_cnt}, 16'd0);
        reset = 1'b0;
`endif

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 8-bit processor, directly upstream of the decode stage.
- Holds the 8-bit PC and drives a request/acknowledge instruction-memory port.
- Presents `inst` plus its fetch address on an IF/ID register consumed by decode.
- Honours back-pressure from decode and redirects from resolved jumps (J/JC).

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- NOP_INST, 8'h00, instruction driven on `inst` whenever `inst_valid` is 0.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; high in S_FETCH and S_DRAIN.
- imem_addr  output  8  fetch address; equals PC register.
- imem_ack  input  1  memory has returned `imem_data` for the current request this cycle.
- imem_data  input  8  instruction byte, valid only when `imem_ack` is 1.
- stall  input  1  decode cannot accept a new instruction this cycle.
- redirect  input  1  taken jump; overrides sequential fetch.
- redirect_target  input  8  new PC when `redirect` is 1.
- inst  output  8  IF/ID instruction register.
- PCout  output  8  address of `inst` (IF/ID register).
- inst_valid  output  1  `inst`/`PCout` hold a live instruction.

Behaviour:
- **Reset** (sync, priority over everything):
  - PC=RESET_PC, state=S_FETCH, inst=NOP_INST, PCout=8'h00, inst_valid=0, skid empty.
  - Any in-flight memory request is abandoned; memory must tolerate this.
- **Memory rules:** while `imem_req`=1, `imem_addr` is stable until the cycle `imem_ack`=1. `imem_ack` with `imem_req`=0 is ignored.
- **Output register** may load only when `out_free` = !inst_valid || !stall.
- **State S_FETCH:**
  - On ack with out_free: inst<=imem_data, PCout<=PC, inst_valid<=1, PC<=PC+1, stay S_FETCH.
  - On ack without out_free: write {imem_data, PC} to skid, PC<=PC+1, go S_HOLD.
  - No ack: if out_free, inst_valid<=0 and inst<=NOP_INST (bubble).
- **State S_HOLD:**
  - `imem_req`=0.
  - When out_free: skid moves to the output register, skid empties, go S_FETCH.
- **State S_DRAIN:**
  - Entered on redirect while a request is pending without ack.
  - Keep `imem_req`=1 at the old address; discard data on ack.
  - On ack: PC<=latched target, go S_FETCH.
- **Redirect** (priority below reset) in any state:
  - inst_valid<=0, inst<=NOP_INST, skid flushed.
  - S_FETCH with ack in the same cycle: data discarded, PC<=target, stay S_FETCH.
  - S_FETCH without ack: target latched, go S_DRAIN.
  - S_HOLD: PC<=target, go S_FETCH.
  - S_DRAIN: latched target replaced by the new one.
- **Stall vs. output:** stall with inst_valid=1 holds inst/PCout unchanged. Stall with inst_valid=0 does not block loading.
- **Arithmetic:** PC increments modulo 256 (8'hFF -> 8'h00), with no flag.
- **Latency:** with zero-wait memory (ack in the request cycle), one instruction per cycle; inst_valid rises 1 cycle after reset deasserts.

Optional Feature:
- Macro: IF_STALL_CNT_EN.
- With the macro defined:
  - Adds output `stall_cnt[15:0]` = cycles with inst_valid && stall, saturating at 16'hFFFF.
  - Adds output `flush_cnt[7:0]` = redirects that discarded a valid or in-flight instruction, saturating.
  - Both counters clear on reset.
- Without the macro: neither port nor counter logic exists; all other behaviour is identical.

Decomposition:
- **Shared package `if_pkg`:**
  - State encoding S_FETCH=2'd0, S_HOLD=2'd1, S_DRAIN=2'd2.
  - NOP_INST default constant.
  - PC/instruction width constant of 8, shared with decode.
- **Sub-module `if_skid_buf`:** 1-entry buffer of {inst, pc} with load, unload, flush and full flag. It is the only natural split.

Test Plan:
- **Reset and sequential fetch:** reset 2 cycles, zero-wait memory returning data = addr ^ 8'hA5 -> after reset, PCout = 00,01,02… each cycle, inst = A5,A4,A7…, inst_valid=1 continuously.
- **Back-pressure:**
  - Stimulus: stall=1 for 3 cycles while PCout=8'h04, ack arriving.
  - Required: inst/PCout hold 04; skid captures 05; imem_req=0 in S_HOLD.
  - After stall drops: 05 then 06 appear with no loss or duplication.
- **Redirect with pending request:**
  - Stimulus: memory with 2-cycle ack latency; redirect to 8'h40 the cycle after a request to 8'h10 is issued.
  - Required: imem_addr stays 8'h10 until ack; data discarded; next request is at 8'h40; next valid PCout=8'h40.
- **Redirect coincident with ack and stall:**
  - Stimulus: redirect to 8'h80 with ack at 8'h22, stall=1, skid full.
  - Required: inst_valid=0 next cycle; skid empty; PC=8'h80; no stale 8'h21/8'h22 ever output.
- **Wrap and mid-operation reset:**
  - Stimulus: redirect to 8'hFE, run 3 fetches.
  - Required: PCout = FE, FF, 00.
  - Then assert reset during S_HOLD: next cycle inst_valid=0, PC=RESET_PC, state S_FETCH.
- **IF_STALL_CNT_EN build:**
  - Stimulus: 5 stalled-valid cycles, then 2 flushing redirects.
  - Required: stall_cnt=5, flush_cnt=2; both 0 after reset.
